// File: rtl/cr_fifo_rd_skid_if.sv
// Handshake bundle between the read-skid stage, the show-ahead FIFO it pops
// and the downstream consumer. The master side is the skid stage itself.
interface cr_fifo_rd_skid_if #(
    parameter int N_DATA_BITS = 64
);
    logic                   fifo_empty;
    logic [N_DATA_BITS-1:0] fifo_rdata;
    logic                   fifo_ren;
    logic                   out_valid;
    logic [N_DATA_BITS-1:0] out_data;
    logic                   out_ready;

    // Skid stage: pops the FIFO and sources the output stream.
    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  out_ready,
        output fifo_ren,
        output out_valid,
        output out_data
    );

    // Environment: the FIFO plus the consumer.
    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output out_ready,
        input  fifo_ren,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/cr_fifo_rd_skid.sv
// Read-side skid stage for a show-ahead FIFO. Pops the FIFO into a 2-entry
// main/skid buffer and presents a fully registered valid/ready stream.
// The pop strobe never depends on out_ready, and out_data/out_valid come
// straight from registers, so both sides are timing-isolated.
module cr_fifo_rd_skid #(
    parameter int N_DATA_BITS = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cr_fifo_rd_skid_if.master    bus,
    input  logic                 clear,
    output logic [CNT_W-1:0]     xfer_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                 state_reg;
    logic                   out_valid_reg;
    logic [N_DATA_BITS-1:0] main_q;
    logic [N_DATA_BITS-1:0] skid_q;
    logic [CNT_W-1:0]       xfer_cnt_reg;

    logic push;
    logic pop;

    // Pop the FIFO whenever it has a word and there is room; TWO is full.
    assign bus.fifo_ren = ~bus.fifo_empty & ~clear & rst_n & (state_reg != S_TWO);

    assign push = bus.fifo_ren;
    assign pop  = out_valid_reg & bus.out_ready;

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = main_q;
    assign xfer_cnt      = xfer_cnt_reg;

    // Occupancy FSM with buffer moves; skid_q always holds the younger word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_EMPTY;
            out_valid_reg <= 1'b0;
            main_q        <= '0;
            skid_q        <= '0;
            xfer_cnt_reg  <= '0;
        end else begin
            // A transfer completing in a clear cycle is still counted.
            if (pop) begin
                xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
            end

            if (clear) begin
                // Flush drops buffered words; the data registers keep their contents.
                state_reg     <= S_EMPTY;
                out_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_EMPTY: begin
                        if (push) begin
                            main_q        <= bus.fifo_rdata;
                            state_reg     <= S_ONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                    S_ONE: begin
                        if (push && pop) begin
                            main_q <= bus.fifo_rdata;
                        end else if (push) begin
                            skid_q    <= bus.fifo_rdata;
                            state_reg <= S_TWO;
                        end else if (pop) begin
                            state_reg     <= S_EMPTY;
                            out_valid_reg <= 1'b0;
                        end
                    end
                    S_TWO: begin
                        if (pop) begin
                            main_q    <= skid_q;
                            state_reg <= S_ONE;
                        end
                    end
                    default: begin
                        state_reg     <= S_EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
